// File: rtl/window_stream_unpacker.sv
// Strips the look-ahead overlap from windowed hash-engine beats and re-serialises the payload into OUT_BYTES beats.
// Optional overlap consistency checker: define WINDOW_UNPACK_OVERLAP_CHECK_EN.
module window_stream_unpacker #(
    parameter int unsigned HASH_ISSUE_WIDTH = 16,
    parameter int unsigned META_HISTORY_LEN = 5,
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned OUT_BYTES        = 4
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               input_valid,
    output logic                                               input_ready,
    input  logic                                               input_delim,
    input  logic [ADDR_WIDTH-1:0]                              input_head_addr,
    input  logic [(HASH_ISSUE_WIDTH+META_HISTORY_LEN-1)*8-1:0] input_data,
    output logic                                               output_valid,
    input  logic                                               output_ready,
    output logic [ADDR_WIDTH-1:0]                              output_addr,
    output logic [OUT_BYTES*8-1:0]                             output_data,
    output logic                                               output_last,
    output logic                                               output_delim,
    output logic                                               addr_error,
    output logic                                               overlap_error
);

    localparam int unsigned WIN_BYTES = HASH_ISSUE_WIDTH + META_HISTORY_LEN - 1;
    localparam int unsigned IN_W      = WIN_BYTES * 8;
    localparam int unsigned PAY_W     = HASH_ISSUE_WIDTH * 8;
    localparam int unsigned OV_W      = (META_HISTORY_LEN - 1) * 8;
    localparam int unsigned OUT_W     = OUT_BYTES * 8;
    localparam int unsigned SUB       = HASH_ISSUE_WIDTH / OUT_BYTES;
    localparam int unsigned SUB_W     = (SUB > 1) ? $clog2(SUB) : 1;

    logic                  full_q, full_d;
    logic [SUB_W-1:0]      sub_idx_q, sub_idx_d;
    logic [PAY_W-1:0]      data_q, data_d;
    logic [ADDR_WIDTH-1:0] head_q, head_d;
    logic                  delim_q, delim_d;
    logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;
    logic                  addr_err_q, addr_err_d;

    logic is_last;
    logic accept;

    assign is_last = (sub_idx_q == SUB_W'(SUB - 1));
    assign accept  = input_valid && input_ready;

    // Holding register, sub-beat sequencing and address continuity tracking
    always_comb begin
        full_d     = full_q;
        sub_idx_d  = sub_idx_q;
        data_d     = data_q;
        head_d     = head_q;
        delim_d    = delim_q;
        exp_addr_d = exp_addr_q;
        addr_err_d = addr_err_q;
        if (accept) begin
            full_d     = 1'b1;
            sub_idx_d  = '0;
            data_d     = input_data[PAY_W-1:0];
            head_d     = input_head_addr;
            delim_d    = input_delim;
            exp_addr_d = input_head_addr + ADDR_WIDTH'(HASH_ISSUE_WIDTH);
            if (input_head_addr != exp_addr_q) begin
                addr_err_d = 1'b1;
            end
        end else if (full_q && output_ready) begin
            if (is_last) begin
                full_d    = 1'b0;
                sub_idx_d = '0;
            end else begin
                sub_idx_d = sub_idx_q + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= 1'b0;
            sub_idx_q  <= '0;
            data_q     <= '0;
            head_q     <= '0;
            delim_q    <= 1'b0;
            exp_addr_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            sub_idx_q  <= sub_idx_d;
            data_q     <= data_d;
            head_q     <= head_d;
            delim_q    <= delim_d;
            exp_addr_q <= exp_addr_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Output view of the held beat; ready accepts a new beat as the last sub-beat leaves
    always_comb begin
        output_valid = full_q;
        output_last  = is_last;
        output_delim = is_last && delim_q;
        output_addr  = head_q + (ADDR_WIDTH'(sub_idx_q) * ADDR_WIDTH'(OUT_BYTES));
        output_data  = '0;
        for (int i = 0; i < SUB; i++) begin
            if (sub_idx_q == SUB_W'(i)) begin
                output_data = data_q[i*OUT_W +: OUT_W];
            end
        end
        input_ready  = !full_q || (full_q && output_ready && is_last);
        addr_error   = addr_err_q;
    end

`ifdef WINDOW_UNPACK_OVERLAP_CHECK_EN
    logic [OV_W-1:0] ov_q, ov_d;
    logic            prev_valid_q, prev_valid_d;
    logic            prev_delim_q, prev_delim_d;
    logic            ov_err_q, ov_err_d;

    // Previous beat's look-ahead must equal the head of the next beat within a block
    always_comb begin
        ov_d         = ov_q;
        prev_valid_d = prev_valid_q;
        prev_delim_d = prev_delim_q;
        ov_err_d     = ov_err_q;
        if (accept) begin
            ov_d         = input_data[PAY_W +: OV_W];
            prev_valid_d = 1'b1;
            prev_delim_d = input_delim;
            if (prev_valid_q && !prev_delim_q && (input_data[OV_W-1:0] != ov_q)) begin
                ov_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q         <= '0;
            prev_valid_q <= 1'b0;
            prev_delim_q <= 1'b0;
            ov_err_q     <= 1'b0;
        end else begin
            ov_q         <= ov_d;
            prev_valid_q <= prev_valid_d;
            prev_delim_q <= prev_delim_d;
            ov_err_q     <= ov_err_d;
        end
    end

    assign overlap_error = ov_err_q;
`else
    logic unused_overlap;
    assign unused_overlap = ^input_data[IN_W-1:PAY_W];
    assign overlap_error  = 1'b0;
`endif

endmodule

// File: tb/tb_window_stream_unpacker.sv
// Scoreboard bench for window_stream_unpacker: directed plan items plus randomized traffic.
module tb_window_stream_unpacker;

    localparam int unsigned HIW  = 16;
    localparam int unsigned MHL  = 5;
    localparam int unsigned AW   = 32;
    localparam int unsigned OB   = 4;
    localparam int unsigned SUB  = HIW / OB;
    localparam int unsigned WINB = HIW + MHL - 1;
    localparam int unsigned OVB  = MHL - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              input_valid = 1'b0;
    logic              input_ready;
    logic              input_delim = 1'b0;
    logic [AW-1:0]     input_head_addr = '0;
    logic [WINB*8-1:0] input_data = '0;
    logic              output_valid;
    logic              output_ready = 1'b1;
    logic [AW-1:0]     output_addr;
    logic [OB*8-1:0]   output_data;
    logic              output_last;
    logic              output_delim;
    logic              addr_error;
    logic              overlap_error;

    window_stream_unpacker #(
        .HASH_ISSUE_WIDTH(HIW), .META_HISTORY_LEN(MHL), .ADDR_WIDTH(AW), .OUT_BYTES(OB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .input_valid(input_valid), .input_ready(input_ready), .input_delim(input_delim),
        .input_head_addr(input_head_addr), .input_data(input_data),
        .output_valid(output_valid), .output_ready(output_ready), .output_addr(output_addr),
        .output_data(output_data), .output_last(output_last), .output_delim(output_delim),
        .addr_error(addr_error), .overlap_error(overlap_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [OB*8-1:0] data;
        logic            last;
        logic            delim;
    } sb_t;

    sb_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  rmode  = 0;   // 0 always ready, 1 random, 2 pattern 1,0,0,1, 3 driven by main
    bit  done   = 1'b0;

    // reference model state
    logic [AW-1:0] m_exp_addr = '0;
    logic          m_addr_err = 1'b0;
    logic          m_ov_err   = 1'b0;
    logic          m_prev_valid = 1'b0;
    logic          m_prev_delim = 1'b0;
    logic [OVB*8-1:0] m_prev_ov = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return a[7:0];
    endfunction

    function automatic logic [WINB*8-1:0] mk_window(input logic [AW-1:0] head, input int corrupt);
        logic [WINB*8-1:0] w;
        for (int i = 0; i < WINB; i++) begin
            w[i*8 +: 8] = mem_byte(head + AW'(i));
            if (i == corrupt) w[i*8 +: 8] = w[i*8 +: 8] ^ 8'h5A;
        end
        return w;
    endfunction

    task automatic send(input logic [AW-1:0] head, input int corrupt, input logic dl);
        bit acc;
        int n = 0;
        input_valid     = 1'b1;
        input_head_addr = head;
        input_data      = mk_window(head, corrupt);
        input_delim     = dl;
        forever begin
            @(negedge clk);
            acc = input_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout: head %0h not accepted within 200 cycles", head);
                break;
            end
        end
        input_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d sub-beats pending expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        input_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // output_ready driver
    initial begin
        int pidx = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: output_ready = 1'b1;
                1: output_ready = 1'($urandom_range(0, 1));
                2: begin
                    output_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
                    pidx++;
                end
                default: ;
            endcase
        end
    end

    // monitor: compares DUT against scoreboard, feeds model on each accepted beat
    initial begin
        while (!done) begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_out_valid", 64'(output_valid), 64'd0);
                chk("rst_in_ready", 64'(input_ready), 64'd1);
                chk("rst_addr_error", 64'(addr_error), 64'd0);
                chk("rst_overlap_error", 64'(overlap_error), 64'd0);
                q.delete();
                m_exp_addr = '0; m_addr_err = 1'b0; m_ov_err = 1'b0;
                m_prev_valid = 1'b0; m_prev_delim = 1'b0; m_prev_ov = '0;
            end else begin
                chk("out_valid", 64'(output_valid), 64'(q.size() != 0));
                chk("in_ready", 64'(input_ready),
                    64'((q.size() == 0) || (output_ready && q.size() == 1)));
                chk("addr_error", 64'(addr_error), 64'(m_addr_err));
                chk("overlap_error", 64'(overlap_error), 64'(m_ov_err));
                if (output_valid && q.size() != 0) begin
                    chk("out_addr", 64'(output_addr), 64'(q[0].addr));
                    chk("out_data", 64'(output_data), 64'(q[0].data));
                    chk("out_last", 64'(output_last), 64'(q[0].last));
                    chk("out_delim", 64'(output_delim), 64'(q[0].delim));
                    if (output_ready) void'(q.pop_front());
                end
                if (input_valid && input_ready) begin
                    for (int k = 0; k < SUB; k++) begin
                        sb_t e;
                        e.addr  = input_head_addr + AW'(k * OB);
                        e.data  = input_data[k*OB*8 +: OB*8];
                        e.last  = (k == SUB - 1);
                        e.delim = e.last && input_delim;
                        q.push_back(e);
                    end
                    if (input_head_addr != m_exp_addr) m_addr_err = 1'b1;
                    m_exp_addr = input_head_addr + AW'(HIW);
`ifdef WINDOW_UNPACK_OVERLAP_CHECK_EN
                    if (m_prev_valid && !m_prev_delim && input_data[OVB*8-1:0] != m_prev_ov)
                        m_ov_err = 1'b1;
`endif
                    m_prev_valid = 1'b1;
                    m_prev_delim = input_delim;
                    m_prev_ov    = input_data[HIW*8 +: OVB*8];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] cur;
        do_reset();

        rmode = 0;
        send(32'd0, -1, 1'b0); send(32'd16, -1, 1'b0); send(32'd32, -1, 1'b0);
        drain();

        do_reset();
        send(32'd0, -1, 1'b1); send(32'd16, -1, 1'b0);
        drain();

        do_reset();
        send(32'd0, -1, 1'b0); send(32'd48, -1, 1'b0); send(32'd64, -1, 1'b0);
        drain();

        do_reset();
        rmode = 2;
        for (int i = 0; i < 6; i++) send(AW'(16 * i), -1, 1'b0);
        drain();
        rmode = 0;

        do_reset();
        send(32'd0, -1, 1'b0); send(32'd16, 1, 1'b0);
        drain();
        do_reset();
        send(32'd0, -1, 1'b1); send(32'd16, 1, 1'b0);
        drain();

        // reset while the third sub-beat is pending
        do_reset();
        rmode = 3;
        output_ready = 1'b0;
        send(32'd0, -1, 1'b0);
        output_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        output_ready = 1'b0;
        chk("pre_rst_addr", 64'(output_addr), 64'd8);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(output_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        output_ready = 1'b1;
        rmode = 0;
        send(32'd0, -1, 1'b0);
        drain();

        // randomized traffic
        do_reset();
        rmode = 1;
        cur = '0;
        for (int i = 0; i < 300; i++) begin
            int corrupt = -1;
            if ($urandom_range(0, 9) == 0) cur = cur + AW'(16 * $urandom_range(1, 4));
            if ($urandom_range(0, 9) == 0) corrupt = int'($urandom_range(0, WINB - 1));
            send(cur, corrupt, 1'($urandom_range(0, 9) == 0));
            cur = cur + AW'(HIW);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        rmode = 0;
        drain();

        done = 1'b1;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
